// File: rtl/stream_pkg.sv
// stream_pkg: definitions shared by the stream multiplexer blocks.
//   MODE_FIXED / MODE_RR : encoding of the 'mode' input
//   ch_width()           : channel-index width for an N-channel block, at least 1
package stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single channel index bit is still needed when N = 2 (or below).
    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req   [N]  : request vector
//   ptr   [CW] : index of the most recent winner; the search starts at ptr+1
//   grant [N]  : one-hot grant of the first requester at or after ptr+1 in
//                ascending order, wrapping N-1 -> 0; all zero if nobody requests
module rr_arbiter
    import stream_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = ch_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant
);

    // One extra bit so ptr + step (at most 2N-1) never overflows before the wrap.
    localparam int IW = CW + 1;

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        // NOTE: every variable gets a value before any conditional code, so no
        // path through the block leaves one unassigned and no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int s = 1; s <= N; s++) begin
            idx = {1'b0, ptr} + IW'(s);
            // Wrap by subtraction rather than by truncation so N need not be 2^k.
            if (idx >= IW'(N)) begin
                idx = idx - IW'(N);
            end
            if (!found && req[idx[CW-1:0]]) begin
                grant[idx[CW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit stream multiplexer with a registered output.
// Arbitration is either fixed (channel 'sel') or round-robin, chosen by 'mode'.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_data  [N*W]         : channel i data in bits [i*W +: W]
//   in_valid [N]           : per-channel valid
//   in_ready [N]           : per-channel ready, at most one bit high
//   mode                   : MODE_FIXED or MODE_RR
//   sel      [CW]          : fixed-mode channel; values >= N select nothing
//   out_data [W], out_ch [CW], out_valid, out_ready : output stream
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int CW = ch_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [CW-1:0]     sel,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [CW-1:0] ptr;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  fixed_grant;
    logic [N-1:0]  grant;
    logic [CW-1:0] grant_idx;
    logic          load;
    logic          take;

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant)
    );

    always_comb begin
        fixed_grant = '0;
        if (int'(sel) < N) begin
            fixed_grant[sel] = in_valid[sel];
        end
    end

    assign grant = (mode == MODE_RR) ? rr_grant : fixed_grant;

    // The output register can take a word when it is empty or being drained.
    assign load = ~out_valid | out_ready;

    // rst_n gates ready so no producer sees a handshake while reset is held.
    assign in_ready = grant & {N{load & rst_n}};
    assign take     = |in_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            // Last winner = N-1 makes the first round-robin search start at 0.
            ptr       <= CW'(N - 1);
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values, independent of statement order.
            if (take) begin
                out_data  <= in_data[int'(grant_idx)*W +: W];
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                ptr       <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: self-checking bench for stream_mux_rr, with an N=4 and an
// N=3 instance. A behavioural model predicts grants and the output word; a
// compare process checks both instances every falling edge, and directed
// phases add literal expectations from hand-worked sequences.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4, in_ready4;
    logic        mode4, out_ready4, out_valid4;
    logic [1:0]  sel4, out_ch4;
    logic [7:0]  out_data4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_ch3;
    logic [7:0]  out_data3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(4), .W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .mode(mode4), .sel(sel4), .out_data(out_data4),
        .out_ch(out_ch4), .out_valid(out_valid4), .out_ready(out_ready4)
    );

    stream_mux_rr #(.N(3), .W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models the N=4 instance, index 1 the N=3 instance.
    logic       m_valid [2] = '{1'b0, 1'b0};
    logic [7:0] m_data  [2] = '{8'h0, 8'h0};
    int         m_ch    [2] = '{0, 0};
    int         m_ptr   [2] = '{3, 2};

    // Who would win: fixed mode takes sel if in range and valid; round-robin
    // scans (ptr+1 .. ptr+n) mod n and takes the first valid channel.
    function automatic logic [3:0] exp_grant(input int n, input logic [3:0] v,
                                             input logic md, input int s, input int p);
        logic [3:0] g;
        g = '0;
        if (md == 1'b0) begin
            if (s < n && v[s]) g[s] = 1'b1;
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (p + k) % n;
                if (v[c]) begin
                    g[c] = 1'b1;
                    return g;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] exp_ready(input int k, input int n, input logic [3:0] v,
                                             input logic md, input int s, input logic ordy);
        if (!rst_n) return 4'b0;
        if (m_valid[k] && !ordy) return 4'b0;
        return exp_grant(n, v, md, s, m_ptr[k]);
    endfunction

    task automatic model_edge(input int k, input int n, input logic [31:0] d,
                              input logic [3:0] v, input logic md, input int s,
                              input logic ordy);
        logic [3:0] g;
        g = exp_ready(k, n, v, md, s, ordy);
        if (g != 4'b0) begin
            for (int c = 0; c < n; c++) begin
                if (g[c]) begin
                    m_ch[k]   = c;
                    m_ptr[k]  = c;
                    m_data[k] = d[c*8 +: 8];
                end
            end
            m_valid[k] = 1'b1;
        end else if (m_valid[k] && ordy) begin
            m_valid[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 1'b0;
                m_data[k]  = 8'h0;
                m_ch[k]    = 0;
            end
            m_ptr[0] = 3;
            m_ptr[1] = 2;
        end else begin
            model_edge(0, 4, in_data4, in_valid4, mode4, int'(sel4), out_ready4);
            model_edge(1, 3, {8'h0, in_data3}, {1'b0, in_valid3}, mode3, int'(sel3), out_ready3);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("n4_in_ready", 32'(in_ready4),
              32'(exp_ready(0, 4, in_valid4, mode4, int'(sel4), out_ready4)));
        check("n4_out_valid", 32'(out_valid4), 32'(m_valid[0]));
        check("n4_out_data",  32'(out_data4),  32'(m_data[0]));
        check("n4_out_ch",    32'(out_ch4),    32'(m_ch[0]));
        check("n3_in_ready", 32'(in_ready3),
              32'(exp_ready(1, 3, {1'b0, in_valid3}, mode3, int'(sel3), out_ready3)));
        check("n3_out_valid", 32'(out_valid3), 32'(m_valid[1]));
        check("n3_out_data",  32'(out_data3),  32'(m_data[1]));
        check("n3_out_ch",    32'(out_ch3),    32'(m_ch[1]));
    end

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        rst_n      = 1'b1;
        in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid4  = 4'hF;
        mode4      = 1'b1;
        sel4       = 2'd0;
        out_ready4 = 1'b1;
        in_data3   = {8'hB2, 8'hB1, 8'hB0};
        in_valid3  = 3'b000;
        mode3      = 1'b1;
        sel3       = 2'd0;
        out_ready3 = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with every channel valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid4), 32'd0);
        check("rst_in_ready",  32'(in_ready4),  32'd0);
        check("rst_out_data",  32'(out_data4),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin fairness, then sparse requests (1 and 3) from ptr = 3.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) in_valid4 = 4'b1010;
            @(negedge clk);
            check("fair_ch",    32'(out_ch4),    32'(i));
            check("fair_data",  32'(out_data4),  32'(8'hA0 + i));
            check("fair_valid", 32'(out_valid4), 32'd1);
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            if (j == 3) begin
                mode4            = 1'b0;
                sel4             = 2'd2;
                in_valid4        = 4'b0100;
                in_data4[23:16]  = 8'h5C;
            end
            @(negedge clk);
            check("sparse_ch",   32'(out_ch4),   (j % 2 == 1) ? 32'd3 : 32'd1);
            check("sparse_data", 32'(out_data4), (j % 2 == 1) ? 32'hA3 : 32'hA1);
            if (j < 3) check("sparse_rdy02", 32'(in_ready4 & 4'b0101), 32'd0);
        end

        // Fixed select of channel 2, then sel = 3 with channel 3 idle.
        @(posedge clk); #1;
        sel4 = 2'd3;
        @(negedge clk);
        check("fixed_data",  32'(out_data4),  32'h5C);
        check("fixed_ch",    32'(out_ch4),    32'd2);
        check("fixed_rdy",   32'(in_ready4),  32'd0);
        @(posedge clk); #1;
        sel4       = 2'd1;
        in_valid4  = 4'b0010;
        out_ready4 = 1'b0;
        @(negedge clk);
        check("drain_valid", 32'(out_valid4), 32'd0);
        check("drain_data",  32'(out_data4),  32'h5C);
        check("drain_ch",    32'(out_ch4),    32'd2);

        // Back-pressure: load channel 1, stall 3 cycles while toggling sel/mode.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid4), 32'd1);
            check("stall_data",  32'(out_data4),  32'hA1);
            check("stall_ch",    32'(out_ch4),    32'd1);
            check("stall_rdy",   32'(in_ready4),  32'd0);
            @(posedge clk); #1;
            mode4     = ~mode4;
            sel4      = 2'(k);
            in_valid4 = 4'hF;
        end
        mode4      = 1'b0;
        sel4       = 2'd0;
        in_valid4  = 4'b0001;
        out_ready4 = 1'b1;
        @(negedge clk);
        check("unstall_rdy", 32'(in_ready4), 32'b0001);
        @(posedge clk); #1;
        in_valid4 = 4'b0000;
        @(negedge clk);
        check("reload_valid", 32'(out_valid4), 32'd1);
        check("reload_data",  32'(out_data4),  32'hA0);
        check("reload_ch",    32'(out_ch4),    32'd0);

        // Random traffic on the N=4 instance.
        repeat (300) begin
            @(posedge clk); #1;
            in_data4   = $urandom;
            in_valid4  = 4'($urandom);
            mode4      = 1'($urandom);
            sel4       = 2'($urandom);
            out_ready4 = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid4  = 4'b0;
        out_ready4 = 1'b1;

        // N = 3 wrap, then reset during a stall.
        in_valid3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) out_ready3 = 1'b0;
            @(negedge clk);
            check("wrap3_ch",   32'(out_ch3),   32'(i % 3));
            check("wrap3_data", 32'(out_data3), 32'(8'hB0 + (i % 3)));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("stall3_ch",   32'(out_ch3),    32'd0);
        check("stall3_data", 32'(out_data3),  32'hB0);
        #2 rst_n = 1'b0;
        #1;
        check("rst3_valid",  32'(out_valid3), 32'd0);
        check("rst3_rdy",    32'(in_ready3),  32'd0);
        check("rst4_valid",  32'(out_valid4), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("restart3_ch",   32'(out_ch3),   32'(i));
            check("restart3_data", 32'(out_data3), 32'(8'hB0 + i));
        end

        // Fixed mode with sel beyond the last channel selects nothing.
        @(posedge clk); #1;
        mode3 = 1'b0;
        sel3  = 2'd3;
        @(negedge clk);
        check("oor3_rdy", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("oor3_valid", 32'(out_valid3), 32'd0);

        // Random traffic on the N=3 instance.
        repeat (300) begin
            @(posedge clk); #1;
            in_data3   = 24'($urandom);
            in_valid3  = 3'($urandom);
            mode3      = 1'($urandom);
            sel3       = 2'($urandom);
            out_ready3 = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
